light_btn_cond: RTL and testbench

Input-conditioning stage that sits directly upstream of the traffic-light controller. It synchronises and debounces the three raw push-buttons. It turns each accepted press into a single-cycle red/yellow/green increment pulse plus a "press in progress" flag, which the controller uses to adjust phase durations in configuration mode. It also generates the free-running one-second tick enable that paces the controller's phase counter.

---
 rtl/light_btn_cond_pkg.sv | 25 ++
 rtl/light_btn_cond_if.sv | 20 ++
 rtl/light_btn_cond_btn_debounce.sv | 50 +++++
 rtl/light_btn_cond.sv | 86 ++++++++
 tb/tb_light_btn_cond.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/light_btn_cond_pkg.sv
// rtl/light_btn_cond_pkg.sv - shared constants and cycle-count helpers for the button conditioner
package light_pkg;

  // Mode switch encodings
  localparam logic [1:0] SW_RUN = 2'b00;
  localparam logic [1:0] SW_Y   = 2'b01;
  localparam logic [1:0] SW_G   = 2'b10;
  localparam logic [1:0] SW_R   = 2'b11;

  // Bit positions of the buttons within btn
  localparam int BTN_G = 0;
  localparam int BTN_Y = 1;
  localparam int BTN_R = 2;

  // Clock cycles a button level must be stable before it is accepted
  function automatic int db_cycles(input int clk_hz, input int debounce_ms);
    return clk_hz / 1000 * debounce_ms;
  endfunction

  // Clock cycles per tick_out period
  function automatic int tick_cycles(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/light_btn_cond_if.sv
// rtl/light_btn_cond_if.sv - button/mode inputs and conditioned outputs of the input stage
interface light_btn_cond_if;
  logic [2:0] btn;
  logic [1:0] sw;
  logic       control_r_out;
  logic       control_y_out;
  logic       control_g_out;
  logic       first_out;
  logic       tick_out;

  modport master (
    output btn, sw,
    input  control_r_out, control_y_out, control_g_out, first_out, tick_out
  );

  modport slave (
    input  btn, sw,
    output control_r_out, control_y_out, control_g_out, first_out, tick_out
  );
endinterface

// File: rtl/light_btn_cond_btn_debounce.sv
// rtl/light_btn_cond_btn_debounce.sv - two-flop synchroniser plus stability-counter debouncer for one button
module btn_debounce #(
  parameter int DB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DB_CYC);
  // The counter flips the level on the edge where it would step to DB_CYC-1,
  // so the last stored value before a flip is DB_CYC-2.
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 2);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Bring the raw asynchronous button into the clock domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Accept a new level only after it has differed for DB_CYC-1 consecutive cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= s2;
        rise  <= s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/light_btn_cond.sv
// rtl/light_btn_cond.sv - debounced, gated, prioritised increment pulses plus a free-running tick
module light_btn_cond
  import light_pkg::*;
#(
  parameter int CLK_HZ      = 125_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int TICK_HZ     = 1
) (
  input logic             clk,
  input logic             rst,
  light_btn_cond_if.slave io
);
  localparam int DB_CYC   = db_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int TICK_CYC = tick_cycles(CLK_HZ, TICK_HZ);
  localparam int TW       = $clog2(TICK_CYC);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYC - 1);

  logic [2:0]    level;
  logic [2:0]    rise;
  logic [2:0]    ev;
  logic          accept;
  logic          r_nxt, y_nxt, g_nxt;
  logic          r_q, y_q, g_q;
  logic          first_q;
  logic [TW-1:0] tick_cnt;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_debounce #(.DB_CYC(DB_CYC)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (io.btn[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  // Drop presses in run mode or while a press is still held; red beats yellow beats green
  always_comb begin
    accept = 1'b0;
    ev     = 3'b000;
    r_nxt  = 1'b0;
    y_nxt  = 1'b0;
    g_nxt  = 1'b0;
    accept = (io.sw != SW_RUN) && !first_q;
    ev     = rise & {3{accept}};
    r_nxt  = ev[BTN_R];
    y_nxt  = ev[BTN_Y] & ~ev[BTN_R];
    g_nxt  = ev[BTN_G] & ~ev[BTN_Y] & ~ev[BTN_R];
  end

  // Register the pulses and hold first_out until every debounced button is released
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q     <= 1'b0;
      y_q     <= 1'b0;
      g_q     <= 1'b0;
      first_q <= 1'b0;
    end else begin
      r_q <= r_nxt;
      y_q <= y_nxt;
      g_q <= g_nxt;
      if (r_nxt || y_nxt || g_nxt) begin
        first_q <= 1'b1;
      end else if (level == 3'b000) begin
        first_q <= 1'b0;
      end
    end
  end

  // Free-running 0..TICK_CYC-1 counter pacing the controller
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign io.control_r_out = r_q;
  assign io.control_y_out = y_q;
  assign io.control_g_out = g_q;
  assign io.first_out     = first_q;
  assign io.tick_out      = (tick_cnt == TICK_LAST);
endmodule

// File: tb/tb_light_btn_cond.sv
// tb/tb_light_btn_cond.sv - directed self-checking bench for light_btn_cond
module tb_light_btn_cond;
  logic clk = 1'b0;
  logic rst;

  light_btn_cond_if io ();

  light_btn_cond #(
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (4),
    .TICK_HZ     (100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc;
  int r_n, y_n, g_n;
  int r_at, y_at, g_at;
  int f_n, f_first, f_last;
  int t_n;
  int t_at[$];

  task chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task clr();
    cyc     = 0;
    r_n     = 0;
    y_n     = 0;
    g_n     = 0;
    r_at    = -1;
    y_at    = -1;
    g_at    = -1;
    f_n     = 0;
    f_first = -1;
    f_last  = -1;
    t_n     = 0;
    t_at.delete();
  endtask

  function int tick_at(input int k);
    return (k < t_at.size()) ? t_at[k] : -1;
  endfunction

  task step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (io.control_r_out) begin r_n++; r_at = cyc; end
      if (io.control_y_out) begin y_n++; y_at = cyc; end
      if (io.control_g_out) begin g_n++; g_at = cyc; end
      if (io.first_out) begin
        if (f_n == 0) f_first = cyc;
        f_n++;
        f_last = cyc;
      end
      if (io.tick_out) begin
        t_n++;
        t_at.push_back(cyc);
      end
    end
  endtask

  initial begin
    rst    = 1'b0;
    io.btn = 3'b000;
    io.sw  = 2'b00;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_r", io.control_r_out, 0);
    chk("rst_y", io.control_y_out, 0);
    chk("rst_g", io.control_g_out, 0);
    chk("rst_first", io.first_out, 0);
    chk("rst_tick", io.tick_out, 0);

    // Idle after reset: ticks at 9, 19, 29 and nothing else
    rst = 1'b1;
    clr();
    step(30);
    chk("idle_tick_n", t_n, 3);
    chk("idle_tick_0", tick_at(0), 9);
    chk("idle_tick_1", tick_at(1), 19);
    chk("idle_tick_2", tick_at(2), 29);
    chk("idle_pulses", r_n + y_n + g_n, 0);
    chk("idle_first", f_n, 0);

    // Yellow config, single press held 20 cycles
    io.sw = 2'b01;
    clr();
    io.btn = 3'b010;
    step(20);
    io.btn = 3'b000;
    step(20);
    chk("y_count", y_n, 1);
    chk("y_cycle", y_at, 6);
    chk("y_others", r_n + g_n, 0);
    chk("y_first_on", f_first, 6);
    chk("y_first_off", f_last, 25);
    chk("y_first_len", f_n, 20);

    // Red config, short glitch on red is rejected
    io.sw = 2'b11;
    clr();
    io.btn = 3'b100;
    step(2);
    io.btn = 3'b000;
    step(15);
    chk("gl_pulses", r_n + y_n + g_n, 0);
    chk("gl_first", f_n, 0);

    // Green config, red+green chord then yellow added: one red pulse only
    io.sw = 2'b10;
    clr();
    io.btn = 3'b101;
    step(10);
    io.btn = 3'b111;
    step(10);
    io.btn = 3'b000;
    step(15);
    chk("ch_r_count", r_n, 1);
    chk("ch_r_cycle", r_at, 6);
    chk("ch_y_count", y_n, 0);
    chk("ch_g_count", g_n, 0);
    chk("ch_first_off", f_last, 25);

    // Run mode press, then mode change while held: no pulse
    io.sw = 2'b00;
    clr();
    io.btn = 3'b001;
    step(20);
    io.sw = 2'b10;
    step(10);
    io.btn = 3'b000;
    step(15);
    chk("run_pulses", r_n + y_n + g_n, 0);
    chk("run_first", f_n, 0);

    // Reset mid-press: outputs clear at once, press re-detected after release
    io.sw = 2'b01;
    clr();
    io.btn = 3'b010;
    step(8);
    chk("mr_pre_y", y_n, 1);
    chk("mr_pre_first", io.first_out, 1);
    rst = 1'b0;
    #1;
    chk("mr_first", io.first_out, 0);
    chk("mr_y", io.control_y_out, 0);
    chk("mr_tick", io.tick_out, 0);
    step(3);
    rst = 1'b1;
    clr();
    step(15);
    chk("mr_y_count", y_n, 1);
    chk("mr_y_cycle", y_at, 6);
    chk("mr_tick_0", tick_at(0), 9);
    io.btn = 3'b000;
    step(15);
    chk("mr_y_total", y_n, 1);
    chk("mr_first_off", f_last, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
